phase_control_unit: RTL
=======================

# phase_control_unit

Parametrised multi-phase control sequencer for the 16-bit processor datapath. It owns the phase counter and a run/halt/fault state machine, and latches the decoded instruction once per instruction. It drives all register enables, memory strobes, PC update and ALU opcode. It stretches the fetch and memory phases on a `mem_ready` handshake and faults on memory timeout. It sits between the instruction register/flag register and the datapath muxes.

## Interface
Parameters:
- `PHASES`, default 5: phases per instruction. Legal range 5..8. The last phase (`PHASES-1`) is always write-back. Phases `4..PHASES-2` are idle padding.
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles on `mem_ready` before fault. Legal range 1..255.
- `START_HALTED`, default 1: if 1, reset enters HALTED; if 0, reset enters RUN at phase 0.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  one-cycle pulse; leaves HALTED or FAULT and enters RUN at phase 0
- `mem_ready`  in  1  memory access complete this cycle
- `S`, `Z`, `C`, `V`  in  1 each  flag register outputs
- `instruction`  in  16  IR contents
- `phase`  out  3  current phase; 0 when not in RUN
- `halted`  out  1  state is HALTED
- `fault`  out  1  state is FAULT
- `ir_e`, `ar_e`, `br_e`, `dr_e`, `mdr_e`, `aluc_e`, `flag_e`  out  1 each  register enables
- `mem_e`, `mem_w`  out  1 each  memory strobe, write
- `genr_w`  out  1  general register write
- `pc_inc`, `pc_load`  out  1 each  PC ← PC+1; PC ← PC+1+sign_ext(d)
- `b_sel_imm`, `a_sel_pc`, `wb_sel_mdr`, `wb_sel_imm`, `st_sel_ra`  out  1 each  datapath mux selects
- `alu_instruction`  out  6  `{op,func}` when op=11, else `instruction[15:10]`

## Operation
- Instruction fields:
  - op = `[15:14]`.
  - op 11 ALU, func `[7:4]`: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV, 8–11 shifts (SLL/SLR/SRL/SRA), 12 IN, 13 OUT, 15 HLT.
  - op 00 LD, op 01 ST.
  - op 10: `[13:11]`=000 LI, 100 B, 111 conditional with `[10:8]` = 000 BE, 001 BLT, 010 BLE, 011 BNE.
  - Any other encoding (including func 7, 14) is a NOP: no enables, `pc_inc` in write-back.
- States: RUN, HALTED, FAULT.
  - In HALTED and FAULT, every enable/strobe/select output is 0.
  - `run` → RUN at phase 0 next cycle.
- Phase actions in RUN:
  - P0 fetch: `mem_e`=1, `ir_e`=`mem_ready`. Hold P0 while `mem_ready`=0.
  - P1 decode/read: latch command class and `instruction` fields into an internal register. `ar_e` for ALU two-operand ops, CMP, OUT, ST. `br_e` for ALU two-operand ops, CMP, shifts, LD, ST.
  - P2 execute:
    - `aluc_e`=1 and `dr_e`=1 for ADD..XOR, MOV, shifts, LD, ST, branches.
    - `flag_e`=1 for ADD..CMP and shifts.
    - `b_sel_imm`=1 for shifts, LD, ST, branches. `a_sel_pc`=1 for branches.
    - Branch taken bit registered at end of P2: B always; BE Z; BLT S^V; BLE Z|(S^V); BNE !Z.
  - P3 memory:
    - LD/IN: `mem_e`=1, `mdr_e`=`mem_ready`.
    - ST: `mem_e`=1, `mem_w`=1, `st_sel_ra`=1.
    - Hold P3 while `mem_ready`=0. Other classes pass P3 in one cycle regardless of `mem_ready`.
  - P(PHASES-1) write-back:
    - `genr_w`=1 for ADD..XOR, MOV, shifts, LD, IN, LI. `wb_sel_mdr` for LD/IN. `wb_sel_imm` for LI.
    - `pc_load`=taken for branches. `pc_inc`=!taken for branches, 1 for all others.
    - HLT: no PC change; state → HALTED after this phase.
  - `genr_w`, `pc_inc`, `pc_load` are never asserted outside the write-back phase.
- Wait counter:
  - 8-bit counter, counts cycles held in P0/P3 with `mem_ready`=0. Cleared when `mem_ready`=1 or on phase exit.
  - When the count reaches `MEM_TIMEOUT`: state → FAULT, `fault`=1.
- `run` while in RUN is ignored.

## Timing
- Reset (`rst` high at a clock edge) has priority over everything, including mid-wait and mid-instruction.
  - State → HALTED (or RUN if `START_HALTED`=0), phase=0, wait count=0, latched command=NOP, taken=0.
  - All outputs 0 except `halted`=`START_HALTED`.
- All control outputs are combinational from registered state and the latched command. `alu_instruction` is combinational from `instruction`.
- Minimum instruction latency is `PHASES` cycles. Each wait cycle in P0 or P3 adds one.
- `mem_ready` seen high with `ir_e`/`mdr_e` → advance at that same edge.
- Phase wraps from `PHASES-1` to 0.
- Flags are sampled only in P2. Flag changes in other phases do not affect a branch.

## Test plan
- Reset, `START_HALTED`=1: all outputs 0, `halted`=1. Pulse `run`: `phase` reads 0,1,2,3,4,0 with `mem_ready`=1.
- ADD (0xC000), `mem_ready`=1: `ar_e`/`br_e` in P1; `aluc_e`/`dr_e`/`flag_e` in P2; `genr_w`=1 and `pc_inc`=1 in P4 only. 5 cycles total.
- LD with `mem_ready` low for 3 cycles in P3: P3 lasts 4 cycles, `mdr_e` only on the final cycle, instruction takes 8 cycles.
- BLT (0xB900): with S=1, V=0 in P2 → `pc_load`=1 in P4. With S=1, V=1 → `pc_inc`=1, `pc_load`=0.
- HLT (0xC0F0): after P4, `halted`=1 and no PC strobe. `run` pulse resumes at P0.
- `mem_ready` held 0 in P0 with `MEM_TIMEOUT`=15: `fault`=1 after 15 wait cycles, outputs 0. `rst` mid-wait returns to the reset state.

Source files
------------

// File: rtl/phase_control_unit.sv
// Multi-phase control sequencer for the 16-bit datapath: run/halt/fault FSM,
// phase counter, per-instruction command latch and memory-wait timeout.
module phase_control_unit #(
  parameter int PHASES       = 5,
  parameter int MEM_TIMEOUT  = 15,
  parameter bit START_HALTED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_ready,
  input  logic        S,
  input  logic        Z,
  input  logic        C,
  input  logic        V,
  input  logic [15:0] instruction,
  output logic [2:0]  phase,
  output logic        halted,
  output logic        fault,
  output logic        ir_e,
  output logic        ar_e,
  output logic        br_e,
  output logic        dr_e,
  output logic        mdr_e,
  output logic        aluc_e,
  output logic        flag_e,
  output logic        mem_e,
  output logic        mem_w,
  output logic        genr_w,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        b_sel_imm,
  output logic        a_sel_pc,
  output logic        wb_sel_mdr,
  output logic        wb_sel_imm,
  output logic        st_sel_ra,
  output logic [5:0]  alu_instruction
);
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALTED = 2'd1, ST_FAULT = 2'd2} state_t;
  typedef enum logic [3:0] {
    CL_NOP, CL_ALU2, CL_MOV, CL_CMP, CL_SHIFT, CL_IN, CL_OUT, CL_HLT,
    CL_LD, CL_ST, CL_LI, CL_BR
  } cls_t;

  localparam logic [2:0] WB_PHASE  = 3'(PHASES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] wait_q, wait_d;
  cls_t       cls_q, cls_d, cls_dec, cls_cur;
  logic [2:0] cond_q, cond_d, cond_dec;
  logic       taken_q, taken_d;
  logic       br_ok, mem_hold;
  logic       unused_inputs;

  assign unused_inputs = ^{C, instruction[3:0]};

  // cond encoding: 0 BE, 1 BLT, 2 BLE, 3 BNE, 4 unconditional B
  always_comb begin
    cls_dec  = CL_NOP;
    cond_dec = 3'd0;
    case (instruction[15:14])
      2'b00: cls_dec = CL_LD;
      2'b01: cls_dec = CL_ST;
      2'b10: begin
        if (instruction[13:11] == 3'b000) begin
          cls_dec = CL_LI;
        end else if (instruction[13:11] == 3'b100) begin
          cls_dec  = CL_BR;
          cond_dec = 3'd4;
        end else if (instruction[13:11] == 3'b111 && !instruction[10]) begin
          cls_dec  = CL_BR;
          cond_dec = {1'b0, instruction[9:8]};
        end
      end
      default: begin
        case (instruction[7:4])
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4: cls_dec = CL_ALU2;
          4'd5:                         cls_dec = CL_CMP;
          4'd6:                         cls_dec = CL_MOV;
          4'd8, 4'd9, 4'd10, 4'd11:     cls_dec = CL_SHIFT;
          4'd12:                        cls_dec = CL_IN;
          4'd13:                        cls_dec = CL_OUT;
          4'd15:                        cls_dec = CL_HLT;
          default:                      cls_dec = CL_NOP;
        endcase
      end
    endcase
  end

  // The latch is written at the end of P1, so P1 itself decodes the live IR.
  assign cls_cur = (phase_q == 3'd1) ? cls_dec : cls_q;

  always_comb begin
    case (cond_q)
      3'd0:    br_ok = Z;
      3'd1:    br_ok = S ^ V;
      3'd2:    br_ok = Z | (S ^ V);
      3'd3:    br_ok = !Z;
      default: br_ok = 1'b1;
    endcase
  end

  // mem_ready handshake: mem_e presents an access in P0 (fetch) or P3 (LD/IN/ST);
  // it completes on the first edge with mem_ready high, until then the phase holds.
  assign mem_hold = !mem_ready &&
                    ((phase_q == 3'd0) ||
                     (phase_q == 3'd3 && (cls_cur == CL_LD || cls_cur == CL_IN || cls_cur == CL_ST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_HALTED ? ST_HALTED : ST_RUN;
      phase_q <= 3'd0;
      wait_q  <= 8'd0;
      cls_q   <= CL_NOP;
      cond_q  <= 3'd0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      cls_q   <= cls_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    cls_d   = cls_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    case (state_q)
      ST_RUN: begin
        if (mem_hold) begin
          if (wait_q == WAIT_LAST) begin
            state_d = ST_FAULT;
            phase_d = 3'd0;
            wait_d  = 8'd0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          wait_d = 8'd0;
          if (phase_q == 3'd1) begin
            cls_d  = cls_dec;
            cond_d = cond_dec;
          end
          if (phase_q == 3'd2) taken_d = (cls_q == CL_BR) && br_ok;
          if (phase_q == WB_PHASE) begin
            phase_d = 3'd0;
            if (cls_q == CL_HLT) state_d = ST_HALTED;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      default: begin
        if (run) begin
          state_d = ST_RUN;
          phase_d = 3'd0;
          wait_d  = 8'd0;
        end
      end
    endcase
  end

  assign phase           = (state_q == ST_RUN) ? phase_q : 3'd0;
  assign halted          = (state_q == ST_HALTED);
  assign fault           = (state_q == ST_FAULT);
  assign alu_instruction = (instruction[15:14] == 2'b11) ? {2'b11, instruction[7:4]}
                                                         : instruction[15:10];

  always_comb begin
    ir_e = 1'b0; ar_e = 1'b0; br_e = 1'b0; dr_e = 1'b0; mdr_e = 1'b0;
    aluc_e = 1'b0; flag_e = 1'b0; mem_e = 1'b0; mem_w = 1'b0; genr_w = 1'b0;
    pc_inc = 1'b0; pc_load = 1'b0; b_sel_imm = 1'b0; a_sel_pc = 1'b0;
    wb_sel_mdr = 1'b0; wb_sel_imm = 1'b0; st_sel_ra = 1'b0;
    if (state_q == ST_RUN) begin
      if (phase_q == 3'd0) begin
        mem_e = 1'b1;
        ir_e  = mem_ready;
      end else if (phase_q == 3'd1) begin
        ar_e = cls_cur inside {CL_ALU2, CL_MOV, CL_CMP, CL_OUT, CL_ST};
        br_e = cls_cur inside {CL_ALU2, CL_MOV, CL_CMP, CL_SHIFT, CL_LD, CL_ST};
      end else if (phase_q == 3'd2) begin
        aluc_e    = cls_cur inside {CL_ALU2, CL_MOV, CL_SHIFT, CL_LD, CL_ST, CL_BR};
        dr_e      = aluc_e;
        flag_e    = cls_cur inside {CL_ALU2, CL_CMP, CL_SHIFT};
        b_sel_imm = cls_cur inside {CL_SHIFT, CL_LD, CL_ST, CL_BR};
        a_sel_pc  = (cls_cur == CL_BR);
      end else if (phase_q == 3'd3) begin
        mem_e     = cls_cur inside {CL_LD, CL_IN, CL_ST};
        mdr_e     = (cls_cur inside {CL_LD, CL_IN}) && mem_ready;
        mem_w     = (cls_cur == CL_ST);
        st_sel_ra = (cls_cur == CL_ST);
      end else if (phase_q == WB_PHASE) begin
        genr_w     = cls_cur inside {CL_ALU2, CL_MOV, CL_SHIFT, CL_LD, CL_IN, CL_LI};
        wb_sel_mdr = cls_cur inside {CL_LD, CL_IN};
        wb_sel_imm = (cls_cur == CL_LI);
        if (cls_cur == CL_BR) begin
          pc_load = taken_q;
          pc_inc  = !taken_q;
        end else begin
          pc_inc = (cls_cur != CL_HLT);
        end
      end
    end
  end
endmodule
